// File: rtl/jericalla_pkg.sv
// Shared types and constants for the jericalla program sequencer.
// Instruction word layout, most significant field first: {op, dir1, dir2, dirW}.
package jericalla_pkg;

    localparam int AW_DEF  = 4;
    localparam int OPW_DEF = 4;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_BZ   = 4'hE;

    // Field positions in units of AW, counted from the LSB.
    localparam int FLD_DIRW = 0;
    localparam int FLD_DIR2 = 1;
    localparam int FLD_DIR1 = 2;
    localparam int FLD_OP   = 3;

    function automatic int fld_lsb(input int fld, input int aw);
        return fld * aw;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WRITE,
        S_HALT
    } state_e;

endpackage

// File: rtl/jericalla_prog_mem.sv
// Program store for the sequencer: synchronous write port, registered read port.
module jericalla_prog_mem #(
    parameter  int DEPTH = 16,
    parameter  int IW    = 16,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [IW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [PW-1:0] raddr_i,
    output logic [IW-1:0] rdata_o
);

    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jericalla_sequencer.sv
// Program sequencer driving the register-file/ALU/RAM datapath.
// Optional single-step input enabled by defining JERICALLA_SEQ_STEP_EN.
module jericalla_sequencer
    import jericalla_pkg::*;
#(
    parameter  int PROG_DEPTH = 16,
    parameter  int AW         = AW_DEF,
    parameter  int OPW        = OPW_DEF,
    parameter  int IW         = OPW + 3 * AW,
    localparam int PW         = $clog2(PROG_DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           prog_we,
    input  logic [PW-1:0]  prog_addr,
    input  logic [IW-1:0]  prog_data,
    input  logic           zf,
`ifdef JERICALLA_SEQ_STEP_EN
    input  logic           step,
`endif
    output logic [AW-1:0]  dir1,
    output logic [AW-1:0]  dir2,
    output logic [OPW-1:0] op,
    output logic [AW-1:0]  dirW,
    output logic           en,
    output logic           busy,
    output logic           done,
    output logic [PW-1:0]  pc
);

    localparam int OP_LSB   = fld_lsb(FLD_OP, AW);
    localparam int DIR1_LSB = fld_lsb(FLD_DIR1, AW);
    localparam int DIR2_LSB = fld_lsb(FLD_DIR2, AW);
    localparam int DIRW_LSB = fld_lsb(FLD_DIRW, AW);

    state_e         state_q, state_d;
    logic [PW-1:0]  pc_q, pc_d;
    logic [AW-1:0]  dir1_q, dir1_d, dir2_q, dir2_d, dirw_q, dirw_d;
    logic [OPW-1:0] op_q, op_d;
    logic           zf_q, zf_d;
    logic [IW-1:0]  ir;
    logic           fetch_go;
    logic           mem_we;

`ifdef JERICALLA_SEQ_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    // Loading is locked out while a program runs so it cannot rewrite itself.
    assign mem_we = prog_we && (state_q == S_IDLE || state_q == S_HALT);

    jericalla_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .IW    (IW)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .re_i    (state_q == S_FETCH),
        .raddr_i (pc_q),
        .rdata_o (ir)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        zf_d    = zf_q;
        dir1_d  = dir1_q;
        dir2_d  = dir2_q;
        dirw_d  = dirw_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_go) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir[OP_LSB +: OPW] == OP_HALT) begin
                    state_d = S_HALT;
                end else if (ir[OP_LSB +: OPW] == OP_BZ) begin
                    pc_d    = zf_q ? PW'(ir[DIRW_LSB +: AW]) : pc_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    op_d    = ir[OP_LSB +: OPW];
                    dir1_d  = ir[DIR1_LSB +: AW];
                    dir2_d  = ir[DIR2_LSB +: AW];
                    dirw_d  = ir[DIRW_LSB +: AW];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                zf_d    = zf;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // The last program word ends the run instead of wrapping to 0.
                if (pc_q == PW'(PROG_DEPTH - 1)) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            zf_q    <= 1'b0;
            dir1_q  <= '0;
            dir2_q  <= '0;
            dirw_q  <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            zf_q    <= zf_d;
            dir1_q  <= dir1_d;
            dir2_q  <= dir2_d;
            dirw_q  <= dirw_d;
            op_q    <= op_d;
        end
    end

    assign dir1 = dir1_q;
    assign dir2 = dir2_q;
    assign op   = op_q;
    assign dirW = dirw_q;
    assign pc   = pc_q;
    assign en   = (state_q == S_WRITE);
    assign busy = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                  (state_q == S_EXEC)  || (state_q == S_WRITE);
    assign done = (state_q == S_HALT);

endmodule

// File: tb/tb_jericalla_sequencer.sv
// Self-checking bench for jericalla_sequencer: an instruction-level interpreter
// expands each program into an expected per-cycle output trace.
`timescale 1ns/1ps
module tb_jericalla_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, prog_we, zf, step;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [3:0]  dir1, dir2, op, dirW, pc;
    logic        en, busy, done;

    int checks = 0;
    int errors = 0;

    logic [15:0] shadow [16];
    logic        zf_force_en  = 1'b0;
    logic        zf_force_val = 1'b0;
    logic        m_zfq;
    logic [15:0] m_out;
    logic [22:0] exp_q [$];
    int          n;

    always #5 clk = ~clk;

    jericalla_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .zf        (zf),
`ifdef JERICALLA_SEQ_STEP_EN
        .step      (step),
`endif
        .dir1      (dir1),
        .dir2      (dir2),
        .op        (op),
        .dirW      (dirW),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .pc        (pc)
    );

    // Stand-in ALU zero flag: a fixed function of the operands presented.
    function automatic logic zf_fn(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] s;
        s = o + a + b;
        return (s[1:0] == 2'b00);
    endfunction

    assign zf = zf_force_en ? zf_force_val : zf_fn(op, dir1, dir2);

    function automatic logic zf_model(input logic [15:0] w);
        return zf_force_en ? zf_force_val : zf_fn(w[15:12], w[11:8], w[7:4]);
    endfunction

    function automatic logic [22:0] obs();
        return {en, busy, done, pc, op, dir1, dir2, dirW};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_word(input int a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = 4'(a);
        prog_data = d;
        @(posedge clk); #1;
        prog_we   = 1'b0;
        shadow[a] = d;
    endtask

    // Interpret the shadow program from pc 0; each instruction contributes its
    // cycles: two for fetch/decode, two more (exec, write) for ALU words.
    task automatic build_trace();
        int p;
        logic [15:0] w;
        p = 0;
        exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            w = shadow[p];
            exp_q.push_back({3'b010, 4'(p), m_out});
            exp_q.push_back({3'b010, 4'(p), m_out});
            if (w[15:12] == 4'hF) begin
                exp_q.push_back({3'b001, 4'(p), m_out});
                return;
            end else if (w[15:12] == 4'hE) begin
                p = m_zfq ? int'(w[3:0]) : (p + 1) % 16;
            end else begin
                m_out = w;
                exp_q.push_back({3'b010, 4'(p), m_out});
                exp_q.push_back({3'b110, 4'(p), m_out});
                m_zfq = zf_model(w);
                if (p == 15) begin
                    exp_q.push_back({3'b001, 4'(p), m_out});
                    return;
                end
                p = p + 1;
            end
        end
    endtask

    task automatic run_prog(input string tag, input bit corrupt, input bit rst_at_write,
                            output int en_cnt);
        en_cnt = 0;
        build_trace();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_cyc%0d", tag, i), 32'(obs()), 32'(exp_q[i]));
            if (en) en_cnt++;
            if (rst_at_write && exp_q[i][22]) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                check({tag, "_after_rst"}, 32'(obs()), 32'h0);
                rst_n = 1'b1;
                m_zfq = 1'b0;
                m_out = '0;
                return;
            end
            if (corrupt && i < exp_q.size() - 1) begin
                prog_we   = 1'b1;
                prog_addr = 4'($urandom);
                prog_data = 16'($urandom);
            end
            @(posedge clk); #1;
            prog_we = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; step = 1'b1;
        m_zfq = 1'b0; m_out = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(obs()), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("idle_hold", 32'(obs()), 32'h0);
        end
        for (int a = 0; a < 16; a++) write_word(a, 16'hF000);
        check("idle_after_load", 32'(obs()), 32'h0);

        // Single ALU instruction followed by HALT.
        write_word(0, 16'h2463);
        write_word(1, 16'hF000);
        run_prog("single", 1'b0, 1'b0, n);
        check("single_en_count", n, 1);
        check("single_busy_done", {busy, done}, 2'b01);

        // Branch taken: zf forced high while the ALU word executes.
        write_word(0, 16'h1110);
        write_word(1, 16'hE005);
        write_word(2, 16'hF000);
        write_word(5, 16'hF000);
        zf_force_en = 1'b1; zf_force_val = 1'b1;
        run_prog("bz_taken", 1'b0, 1'b0, n);
        check("bz_taken_pc", pc, 5);
        check("bz_taken_en_count", n, 1);

        zf_force_val = 1'b0;
        run_prog("bz_not_taken", 1'b0, 1'b0, n);
        check("bz_not_taken_pc", pc, 2);
        zf_force_en = 1'b0;

        // Sixteen ALU words with no HALT: ends at pc 15 without wrapping.
        for (int a = 0; a < 16; a++)
            write_word(a, {4'($urandom_range(0, 13)), 12'($urandom)});
        run_prog("end_of_mem", 1'b0, 1'b0, n);
        check("end_of_mem_en_count", n, 16);
        check("end_of_mem_pc", pc, 15);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("end_of_mem_hold", 32'(obs()), 32'(exp_q[exp_q.size() - 1]));
        end

        // Writes attempted during a run must not land; the rerun uses the shadow.
        run_prog("guard_run1", 1'b1, 1'b0, n);
        run_prog("guard_run2", 1'b0, 1'b0, n);
        check("guard_en_count", n, 16);

        // Reset during WRITE, then the untouched program runs again.
        run_prog("rst_mid", 1'b0, 1'b1, n);
        @(posedge clk); #1;
        check("rst_mid_idle", 32'(obs()), 32'h0);
        run_prog("after_rst", 1'b0, 1'b0, n);

        // Random programs with HALTs and forward branches.
        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < 16; a++) begin
                int r;
                r = $urandom_range(0, 9);
                if (a < 15 && r == 0)
                    write_word(a, 16'hF000);
                else if (a < 15 && r <= 2)
                    write_word(a, {4'hE, 8'($urandom), 4'($urandom_range(a + 1, 15))});
                else
                    write_word(a, {4'($urandom_range(0, 13)), 12'($urandom)});
            end
            run_prog($sformatf("rand%0d", t), 1'b0, 1'b0, n);
            check($sformatf("rand%0d_done", t), {busy, done}, 2'b01);
        end

`ifdef JERICALLA_SEQ_STEP_EN
        write_word(0, 16'h1230);
        write_word(1, 16'h2341);
        write_word(2, 16'h3452);
        write_word(3, 16'hF000);
        step  = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (10) begin
            if (en) n++;
            @(posedge clk); #1;
        end
        check("step_hold_en", n, 0);
        check("step_hold_busy_pc", {busy, pc}, {1'b1, 4'd0});
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            @(posedge clk); #1;
            step = 1'b0;
            repeat (6) begin
                if (en) n++;
                @(posedge clk); #1;
            end
        end
        check("step_en_count", n, 3);
        check("step_busy_pc", {busy, pc}, {1'b1, 4'd3});
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("step_done", {busy, done}, 2'b01);
        step = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
